// File: rtl/ysyx_23060180_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060180_lsu_if
//  Description : Bundle of the LSU request/response handshake and the shared
//                word-addressed memory port. The slave modport is the LSU
//                view; the master modport is the core/memory-side view.
//  Revision    : 1.0  initial release
// ============================================================================
interface ysyx_23060180_lsu_if;
  // request from EXECUTE
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  // response to WRITEBACK
  logic        resp_valid;
  logic        resp_err;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;
  // memory port
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rd, resp_rdata,
           mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rd, resp_rdata,
           mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060180_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060180_lsu
//  Description : Load/store unit for the multi-cycle RV32 core (MEMORY stage).
//                One request at a time; byte-lane alignment, write masking,
//                sign/zero extension; one response per request. All outputs
//                are decoded from registered state (Moore).
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_23060180_lsu #(
  parameter int MEM_LAT = 1   // mem_rd cycle to mem_rdata valid, 1..15
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_23060180_lsu_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  // WAIT is entered with this value so that the counter hits zero in the
  // cycle where mem_rdata becomes valid.
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t      state;
  state_t      state_next;

  logic        cap_we;
  logic [2:0]  cap_func3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [4:0]  cap_rd;
  logic [3:0]  lat_cnt;
  logic [31:0] load_data;

  logic        req_bad;
  logic [1:0]  off;

  assign off = cap_addr[1:0];

  // Misalignment / illegal funct3 check on the incoming request
  function automatic logic bad_request(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
    logic illegal;
    logic misaligned;
    if (we) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal || misaligned;
  endfunction

  // Select the addressed lane of a memory word and extend it per funct3
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req_bad = bad_request(bus.req_we, bus.req_func3, bus.req_addr[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = req_bad ? ERR : ACCESS;
      ACCESS:  state_next = cap_we ? DONE : WAIT;
      WAIT:    if (lat_cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency counter and load-data latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_func3 <= 3'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_rd    <= 5'd0;
      lat_cnt   <= 4'd0;
      load_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_we    <= bus.req_we;
            cap_func3 <= bus.req_func3;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_rd    <= bus.req_rd;
            load_data <= 32'd0;
          end
        end
        ACCESS: lat_cnt <= LAT_INIT;
        WAIT: begin
          if (lat_cnt == 4'd0) load_data <= extend_load(cap_func3, off, bus.mem_rdata);
          else                 lat_cnt   <= lat_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode from state and captured fields
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rd    = 5'd0;
    bus.resp_rdata = 32'd0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    bus.mem_wmask  = 4'd0;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      ACCESS: begin
        bus.mem_addr = {cap_addr[31:2], 2'b00};
        if (cap_we) begin
          bus.mem_wr = 1'b1;
          case (cap_func3[1:0])
            2'b00: begin
              bus.mem_wdata = {4{cap_wdata[7:0]}};
              bus.mem_wmask = 4'b0001 << off;
            end
            2'b01: begin
              bus.mem_wdata = {2{cap_wdata[15:0]}};
              bus.mem_wmask = 4'b0011 << off;
            end
            default: begin
              bus.mem_wdata = cap_wdata;
              bus.mem_wmask = 4'b1111;
            end
          endcase
        end else begin
          bus.mem_rd = 1'b1;
        end
      end
      WAIT: bus.mem_addr = {cap_addr[31:2], 2'b00};
      DONE: begin
        bus.mem_addr   = {cap_addr[31:2], 2'b00};
        bus.resp_valid = 1'b1;
        if (!cap_we) begin
          bus.resp_rd    = cap_rd;
          bus.resp_rdata = load_data;
        end
      end
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060180_lsu.md
Name: ysyx_23060180_lsu

Overview:
Load/store unit for the multi-cycle RV32 core; it fills the MEMORY stage between EXECUTE (effective address, store data) and WRITEBACK.
- Accepts one load/store request at a time.
- Drives the shared word-addressed memory port (same fixed-latency protocol as instruction fetch).
- Performs byte-lane alignment, write masking, and sign/zero extension.
- Returns one response per request: load data for rd, or a misalignment/illegal error.

Parameters:
MEM_LAT, 1, cycles from the mem_rd strobe cycle to the cycle mem_rdata is valid; legal range 1..15.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present; sampled only when req_ready=1
req_ready  output  1  LSU idle and able to accept
req_we  input  1  1=store, 0=load
req_func3  input  3  RV32 funct3 (load: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; store: 0 sb, 1 sh, 2 sw)
req_addr  input  32  byte effective address
req_wdata  input  32  store data (rs2), low bits significant
req_rd  input  5  destination register for loads
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  qualifies resp_valid: misaligned or illegal funct3
resp_rd  output  5  rd for loads; 0 for stores and errors
resp_rdata  output  32  extended load data; 0 for stores and errors
mem_rd  output  1  one-cycle read strobe
mem_wr  output  1  one-cycle write strobe
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_wmask  output  4  byte enables, bit i = byte i
mem_rdata  input  32  read data, valid MEM_LAT cycles after the mem_rd cycle

Behaviour:
Reset
- rst high at a rising edge forces state IDLE and clears all captured fields and the latency counter.
- After that edge: req_ready=1; resp_valid, resp_err, mem_rd, mem_wr, mem_wmask=0; resp_rd, resp_rdata, mem_addr, mem_wdata=0.
- Reset mid-operation abandons the request. No response is issued, and strobes drop at that edge.

Outputs
- All outputs are decoded from registered state and registered fields (Moore).
- No input-to-output combinational path.

State machine: IDLE, ACCESS, WAIT, DONE, ERR
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/func3/addr/wdata/rd.
  - Misaligned request goes to ERR: h with addr[0]=1, or w with addr[1:0]!=0.
  - Illegal funct3 goes to ERR: load 3/6/7, or store >2.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Store: mem_wr=1, mem_wdata, mem_wmask. Next state DONE.
  - Load: mem_rd=1, mem_wmask=0. Next state WAIT, counter loaded with MEM_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0 (exactly MEM_LAT cycles after the ACCESS cycle), latch the extended mem_rdata and go to DONE.
- DONE:
  - resp_valid=1, resp_err=0 for one cycle, then IDLE.
- ERR:
  - resp_valid=1, resp_err=1, resp_rd=0, resp_rdata=0 for one cycle, then IDLE.
  - No memory strobe is ever issued for an erroring request.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored, and the core must hold it.
- No response backpressure: the core's FSM consumes resp_valid in the cycle it is high.

Latency, counted from the acceptance edge
- Store: resp_valid 2 cycles later.
- Load: resp_valid 2+MEM_LAT cycles later.
- Error: resp_valid 1 cycle later.
- Back-to-back: a new request is accepted in the cycle after DONE/ERR.

Data rules (off = addr[1:0])
- sb: mem_wdata={4{wdata[7:0]}}, mask=4'b0001<<off.
- sh: mem_wdata={2{wdata[15:0]}}, mask=4'b0011<<off.
- sw: mem_wdata=wdata, mask=4'b1111.
- lb/lbu: byte mem_rdata[8*off+7:8*off], sign-extended / zero-extended.
- lh/lhu: half mem_rdata[16*addr[1]+15:16*addr[1]], sign-extended / zero-extended.
- lw: mem_rdata unchanged.
- req_rd=0 on a load is legal: the response is produced normally with resp_rd=0.
- mem_addr is held from ACCESS through DONE, and is 0 in IDLE/ERR.

Test Plan:
- Reset, then lw addr=0x80000010 rd=5 with mem returning 0xDEADBEEF (MEM_LAT=1) -> mem_rd at +1, mem_addr=0x80000010, resp_valid at +3, resp_rdata=0xDEADBEEF, resp_rd=5.
- lb addr=0x80000003 with mem_rdata=0x80FF7F01 -> resp_rdata=0xFFFFFF80; lbu at the same address -> 0x00000080; lh addr=0x80000002 -> 0xFFFF80FF.
- sb addr=0x80000001 wdata=0x123456AB -> mem_wr one cycle, mem_wdata=0xABABABAB, mem_wmask=4'b0010, resp_valid at +2 with resp_rd=0; sh addr=...2 -> mask 4'b1100.
- lw addr=0x80000006 and sh addr=0x80000001 -> resp_err=1 at +1, mem_rd and mem_wr never asserted; load with func3=3 -> error.
- MEM_LAT=3: lhu addr=...2, mem_rdata=0xBEEF0000 valid only at +3 after ACCESS -> resp_rdata=0x0000BEEF at +5, with req_ready=0 throughout.
- Reset asserted during WAIT -> no resp_valid, req_ready=1 after the edge; then an immediate sw is accepted and completes normally.
